// File: rtl/sort_seq_if.sv
// Valid/ready bundle between a producer, the sorter and a consumer.
// One vector in, one sorted vector plus swap count out.
interface sort_seq_if #(
   parameter int NUM_VALS = 8,
   parameter int WIDTH    = 4
);
   localparam int VW = NUM_VALS * WIDTH;
   localparam int SW = $clog2(NUM_VALS * (NUM_VALS - 1) / 2 + 1);

   logic          in_valid;
   logic          in_ready;
   logic [VW-1:0] in_data;
   logic          out_valid;
   logic          out_ready;
   logic [VW-1:0] out_data;
   logic [SW-1:0] out_swaps;
   logic          busy;

   modport master (
      output in_valid,
      output in_data,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_data,
      input  out_swaps,
      input  busy
   );

   modport slave (
      input  in_valid,
      input  in_data,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_data,
      output out_swaps,
      output busy
   );
endinterface

// File: rtl/sort_seq.sv
// Sequential bubble sorter: one shared compare-swap per cycle,
// early exit on a pass with no swaps, ascending by element index.
module sort_seq #(
   parameter int NUM_VALS = 8,
   parameter int WIDTH    = 4
) (
   input  logic      clk,
   input  logic      rst_n,
   sort_seq_if.slave bus
);
   localparam int VW = NUM_VALS * WIDTH;
   localparam int SW = $clog2(NUM_VALS * (NUM_VALS - 1) / 2 + 1);
   localparam int JW = $clog2(NUM_VALS);
   localparam logic [JW-1:0] LAST = JW'(NUM_VALS - 2);

   typedef enum logic [1:0] {
      IDLE,
      SORT,
      DONE
   } state_e;

   state_e state_q, state_d;

   logic [WIDTH-1:0] vec_q [NUM_VALS];
   logic [WIDTH-1:0] vec_d [NUM_VALS];

   logic [JW-1:0] i_q, i_d;
   logic [JW-1:0] j_q, j_d;
   logic [SW-1:0] cnt_q, cnt_d;
   logic          flag_q, flag_d;

   logic [JW-1:0]    j_nx;
   logic [WIDTH-1:0] lo;
   logic [WIDTH-1:0] hi;
   logic             swap;
   logic             pass_end;
   logic             any_swap;
   logic [VW-1:0]    packed_vec;

   // The single comparator sees the pair (j, j+1).
   assign j_nx     = j_q + 1'b1;
   assign lo       = vec_q[j_q];
   assign hi       = vec_q[j_nx];
   assign swap     = lo > hi;
   assign pass_end = (j_q == LAST - i_q);
   assign any_swap = flag_q | swap;

   always_comb begin
      state_d = state_q;
      vec_d   = vec_q;
      i_d     = i_q;
      j_d     = j_q;
      cnt_d   = cnt_q;
      flag_d  = flag_q;
      unique case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               for (int k = 0; k < NUM_VALS; k++) begin
                  vec_d[k] = bus.in_data[k*WIDTH +: WIDTH];
               end
               i_d     = '0;
               j_d     = '0;
               cnt_d   = '0;
               flag_d  = 1'b0;
               state_d = SORT;
            end
         end
         SORT: begin
            if (swap) begin
               vec_d[j_q]  = hi;
               vec_d[j_nx] = lo;
               cnt_d       = cnt_q + 1'b1;
               flag_d      = 1'b1;
            end
            if (!pass_end) begin
               j_d = j_nx;
            end else if (!any_swap || i_q == LAST) begin
               state_d = DONE;
            end else begin
               i_d    = i_q + 1'b1;
               j_d    = '0;
               flag_d = 1'b0;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         i_q     <= '0;
         j_q     <= '0;
         cnt_q   <= '0;
         flag_q  <= 1'b0;
         for (int k = 0; k < NUM_VALS; k++) begin
            vec_q[k] <= '0;
         end
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         j_q     <= j_d;
         cnt_q   <= cnt_d;
         flag_q  <= flag_d;
         vec_q   <= vec_d;
      end
   end

   always_comb begin
      packed_vec = '0;
      for (int k = 0; k < NUM_VALS; k++) begin
         packed_vec[k*WIDTH +: WIDTH] = vec_q[k];
      end
   end

   // Results are only visible in DONE.
   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.busy      = (state_q != IDLE);
   assign bus.out_data  = (state_q == DONE) ? packed_vec : '0;
   assign bus.out_swaps = (state_q == DONE) ? cnt_q : '0;
endmodule

// File: tb/tb_sort_seq.sv
// Directed and randomised checks of sort_seq:
// results, swap counts, latency, backpressure and reset.
module tb_sort_seq;
   localparam int N  = 8;
   localparam int W  = 4;
   localparam int SW = $clog2(N * (N - 1) / 2 + 1);

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk = 0;
   int   n_fail = 0;

   sort_seq_if #(.NUM_VALS(N), .WIDTH(W)) bus ();

   sort_seq #(.NUM_VALS(N), .WIDTH(W)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [63:0] obs,
                        input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Latency counts the handshake cycle as cycle 0.
   task automatic run_vec(input string tag,
                          input logic [31:0] d,
                          input logic [31:0] ed,
                          input int es,
                          input int el);
      int n;
      @(negedge clk);
      check({tag, "_rdy"}, bus.in_ready, 1);
      bus.in_valid  = 1'b1;
      bus.in_data   = d;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      n = 1;
      while (!bus.out_valid && n < 200) begin
         @(posedge clk);
         #1;
         n++;
      end
      check({tag, "_lat"}, n, el);
      check({tag, "_data"}, bus.out_data, ed);
      check({tag, "_swaps"}, bus.out_swaps, es);
      @(posedge clk);
      #1;
      check({tag, "_idle"}, bus.in_ready, 1);
   endtask

   task automatic run_rand();
      logic [31:0] d;
      logic [31:0] ed;
      logic [3:0]  e [N];
      int          cnt [16];
      int          inv;
      int          p;
      int          n;
      int          stall;
      d = $urandom;
      for (int k = 0; k < N; k++) e[k] = d[k*W +: W];
      inv = 0;
      for (int a = 0; a < N; a++)
         for (int b = a + 1; b < N; b++)
            if (e[a] > e[b]) inv++;
      for (int v = 0; v < 16; v++) cnt[v] = 0;
      for (int k = 0; k < N; k++) cnt[e[k]]++;
      ed = '0;
      p = 0;
      for (int v = 0; v < 16; v++)
         for (int c = 0; c < cnt[v]; c++) begin
            ed[p*W +: W] = 4'(v);
            p++;
         end
      @(negedge clk);
      bus.in_valid  = 1'b1;
      bus.in_data   = d;
      bus.out_ready = 1'b0;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      n = 0;
      while (!bus.out_valid && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("rnd_valid", bus.out_valid, 1);
      stall = $urandom_range(0, 3);
      repeat (stall) begin
         @(posedge clk);
         #1;
      end
      check("rnd_data", bus.out_data, ed);
      check("rnd_swaps", bus.out_swaps, inv);
      @(negedge clk);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("rnd_idle", bus.in_ready, 1);
   endtask

   initial begin
      logic [31:0] hold_d;
      logic        seen;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      #1;
      check("rst_in_ready", bus.in_ready, 1);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_out_data", bus.out_data, 0);
      check("rst_out_swaps", bus.out_swaps, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      run_vec("rev", 32'h0123_4567, 32'h7654_3210, 28, 29);
      run_vec("sorted", 32'h7654_3210, 32'h7654_3210, 0, 8);
      run_vec("one_swap", 32'h7654_3201, 32'h7654_3210, 1, 14);
      run_vec("dups", 32'h1111_1111, 32'h1111_1111, 0, 8);
      run_vec("bubble", 32'h0000_0001, 32'h1000_0000, 7, 14);
      run_vec("eq_top", 32'hF000_000F, 32'hFF00_0000, 6, 14);

      // Backpressure with stray in_valid pulses.
      @(negedge clk);
      bus.in_valid  = 1'b1;
      bus.in_data   = 32'h0123_4567;
      bus.out_ready = 1'b0;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (40) begin
         if (!bus.out_valid) begin
            @(posedge clk);
            #1;
         end
      end
      check("bp_valid", bus.out_valid, 1);
      check("bp_busy", bus.busy, 1);
      hold_d = bus.out_data;
      check("bp_data0", hold_d, 32'h7654_3210);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         bus.in_valid = c[0];
         bus.in_data  = 32'hABCD_0000 | 32'(c);
         @(posedge clk);
         #1;
         check("bp_hold_valid", bus.out_valid, 1);
         check("bp_hold_rdy", bus.in_ready, 0);
         check("bp_hold_data", bus.out_data, 32'h7654_3210);
         check("bp_hold_swaps", bus.out_swaps, 28);
      end
      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp_rel_rdy", bus.in_ready, 1);
      check("bp_rel_valid", bus.out_valid, 0);
      check("bp_rel_data", bus.out_data, 0);

      // Reset during the fifth SORT cycle.
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = 32'h0123_4567;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #3;
      check("mid_busy_pre", bus.busy, 1);
      rst_n = 1'b0;
      #1;
      check("mid_rdy", bus.in_ready, 1);
      check("mid_valid", bus.out_valid, 0);
      check("mid_data", bus.out_data, 0);
      check("mid_busy", bus.busy, 0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (bus.out_valid) seen = 1'b1;
      end
      check("mid_no_ghost", seen, 0);
      run_vec("rev_after_rst", 32'h0123_4567, 32'h7654_3210, 28, 29);

      for (int t = 0; t < 1000; t++) run_rand();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule
